// File: rtl/fft_pkg.sv
// Shared state encoding and FFT geometry constants for the process_fft
// sequencing blocks.
package fft_pkg;

    typedef enum logic [2:0] {
        CFG   = 3'd0,
        FILL  = 3'd1,
        IDLE  = 3'd2,
        START = 3'd3,
        RUN   = 3'd4
    } sched_state_t;

    localparam int          FFT_N        = 4096;
    localparam logic [11:0] FFT_LAST_IDX = 12'hFFF;
    localparam int          HIST_BINS    = 1024;
    localparam logic [7:0]  CFG_FWD      = 8'h01;

endpackage

// File: rtl/fft_scheduler_if.sv
// Control and status bundle between fft_scheduler (master) and the FFT
// core, sample writer and histogram/display path (slave).
interface fft_scheduler_if;

    logic        sample_strobe;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic        start;
    logic        mag_valid;
    logic [11:0] mag_index;
    logic        core_error;
    logic        bank;
    logic        hist_ready;
    logic        busy;
    logic [15:0] dropped;
    logic        fault;

    modport master (
        input  sample_strobe, cfg_tready, mag_valid, mag_index, core_error,
        output cfg_tdata, cfg_tvalid, start, bank, hist_ready, busy, dropped, fault
    );

    modport slave (
        output sample_strobe, cfg_tready, mag_valid, mag_index, core_error,
        input  cfg_tdata, cfg_tvalid, start, bank, hist_ready, busy, dropped, fault
    );

endinterface

// File: rtl/fft_scheduler_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fft_scheduler.sv
// Sequencer for process_fft: one-shot core config, frame fill, periodic
// start pulses per hop, frame completion/timeout and histogram bank select.
//
// state | meaning
// CFG   | offering the config word to the core
// FILL  | waiting for the first FRAME samples
// IDLE  | frame buffer primed, waiting for the next hop
// START | one-cycle launch of process_fft
// RUN   | frame in flight, waiting for the last magnitude bin
module fft_scheduler
    import fft_pkg::*;
#(
    parameter int         HOP      = 1024,
    parameter int         FRAME    = 4096,
    parameter logic [7:0] CFG_WORD = CFG_FWD,
    parameter int         TIMEOUT  = 16384
) (
    input  logic            clk,
    input  logic            reset,
    fft_scheduler_if.master bus
);

    localparam int                FILL_W    = $clog2(FRAME + 1);
    localparam int                TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [11:0]       HOP_LAST  = 12'(HOP - 1);
    localparam logic [FILL_W-1:0] FILL_LOAD = FILL_W'(FRAME);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 1);

    sched_state_t      state, state_next;
    logic [FILL_W-1:0] fill_rem, fill_rem_next;
    logic [11:0]       hop_cnt, hop_cnt_next;
    logic [TMO_W-1:0]  tmo_rem, tmo_rem_next;

    logic cfg_tvalid_q, cfg_tvalid_next;
    logic start_q, start_next;
    logic bank_q, bank_next;
    logic hist_ready_q, hist_ready_next;
    logic busy_q, busy_next;
    logic fault_q, fault_next;

    logic        hop_due;
    logic        drop_inc;
    logic        last_beat;
    logic [15:0] dropped_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CFG;
            fill_rem     <= '0;
            hop_cnt      <= '0;
            tmo_rem      <= '0;
            cfg_tvalid_q <= 1'b0;
            start_q      <= 1'b0;
            bank_q       <= 1'b0;
            hist_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state        <= state_next;
            fill_rem     <= fill_rem_next;
            hop_cnt      <= hop_cnt_next;
            tmo_rem      <= tmo_rem_next;
            cfg_tvalid_q <= cfg_tvalid_next;
            start_q      <= start_next;
            bank_q       <= bank_next;
            hist_ready_q <= hist_ready_next;
            busy_q       <= busy_next;
            fault_q      <= fault_next;
        end
    end

    always_comb begin
        state_next      = state;
        fill_rem_next   = fill_rem;
        hop_cnt_next    = hop_cnt;
        tmo_rem_next    = tmo_rem;
        bank_next       = bank_q;
        hist_ready_next = 1'b0;
        fault_next      = fault_q | bus.core_error;
        hop_due         = 1'b0;
        drop_inc        = 1'b0;
        last_beat       = bus.mag_valid && (bus.mag_index == FFT_LAST_IDX);

        // Hop phase runs continuously once the frame buffer is primed.
        if ((state == IDLE || state == START || state == RUN) && bus.sample_strobe) begin
            if (hop_cnt == HOP_LAST) begin
                hop_cnt_next = '0;
                hop_due      = 1'b1;
            end else begin
                hop_cnt_next = hop_cnt + 12'd1;
            end
        end

        case (state)
            CFG: begin
                fill_rem_next = FILL_LOAD;
                hop_cnt_next  = '0;
                if (cfg_tvalid_q && bus.cfg_tready) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                hop_cnt_next = '0;
                if (bus.sample_strobe) begin
                    if (fill_rem == FILL_W'(1)) begin
                        state_next = IDLE;
                    end else begin
                        fill_rem_next = fill_rem - FILL_W'(1);
                    end
                end
            end
            IDLE: begin
                if (hop_due) begin
                    state_next = START;
                end
            end
            START: begin
                state_next   = RUN;
                tmo_rem_next = TMO_LOAD;
                drop_inc     = hop_due;
            end
            RUN: begin
                drop_inc = hop_due;
                // A frame that completes on its last allowed cycle still counts.
                if (last_beat) begin
                    bank_next       = ~bank_q;
                    hist_ready_next = 1'b1;
                    state_next      = IDLE;
                end else if (tmo_rem == '0) begin
                    fault_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_rem_next = tmo_rem - TMO_W'(1);
                end
            end
            default: begin
                state_next = CFG;
            end
        endcase

        cfg_tvalid_next = (state_next == CFG);
        start_next      = (state_next == START);
        busy_next       = (state_next == START) || (state_next == RUN);
    end

    sat_counter #(
        .WIDTH(16)
    ) u_dropped (
        .clk  (clk),
        .reset(reset),
        .inc  (drop_inc),
        .count(dropped_cnt)
    );

    assign bus.cfg_tdata  = CFG_WORD;
    assign bus.cfg_tvalid = cfg_tvalid_q;
    assign bus.start      = start_q;
    assign bus.bank       = bank_q;
    assign bus.hist_ready = hist_ready_q;
    assign bus.busy       = busy_q;
    assign bus.dropped    = dropped_cnt;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_fft_scheduler.sv
// Scoreboard bench for fft_scheduler: a count-based reference model pushes
// expected pulses/updates into a queue, a negedge monitor pops and compares.
module tb_fft_scheduler;

    localparam int HOP     = 8;
    localparam int FRAME   = 16;
    localparam int TIMEOUT = 64;

    localparam int EV_START = 0;
    localparam int EV_DROP  = 1;
    localparam int EV_HIST  = 2;
    localparam int EV_FAULT = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fft_scheduler_if bus ();

    fft_scheduler #(
        .HOP     (HOP),
        .FRAME   (FRAME),
        .CFG_WORD(8'h01),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];

    bit m_configured, m_primed, m_open, m_bank, m_fault, m_busy, m_cfg_valid;
    int m_filled, m_hop_samples, m_age, m_drops;

    function automatic void note_fail(string name, int act, int want);
        errors++;
        if (errors <= 40)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    endfunction

    function automatic void check(string name, int act, int want);
        checks++;
        if (act != want) note_fail(name, act, want);
    endfunction

    function automatic void push_ev(int kind, int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_configured  = 0;
        m_primed      = 0;
        m_open        = 0;
        m_bank        = 0;
        m_fault       = 0;
        m_busy        = 0;
        m_cfg_valid   = 0;
        m_filled      = 0;
        m_hop_samples = 0;
        m_age         = 0;
        m_drops       = 0;
        exp_q.delete();
    endfunction

    // One clock edge of the reference: counts samples, hops and frame age.
    function automatic void model_step();
        bit hop;
        bit cause;
        bit last;
        hop   = 0;
        cause = bus.core_error;
        last  = bus.mag_valid && (bus.mag_index == 12'hFFF);
        if (!m_configured) begin
            if (m_cfg_valid && bus.cfg_tready) m_configured = 1;
        end else if (!m_primed) begin
            if (bus.sample_strobe) begin
                m_filled++;
                if (m_filled == FRAME) begin
                    m_primed      = 1;
                    m_hop_samples = 0;
                end
            end
        end else begin
            if (bus.sample_strobe) begin
                m_hop_samples++;
                hop = (m_hop_samples % HOP) == 0;
            end
            if (m_open) begin
                m_age++;
                if (hop && m_drops < 65535) begin
                    m_drops++;
                    push_ev(EV_DROP, m_drops);
                end
                if (m_age >= 2 && last) begin
                    m_open = 0;
                    m_bank = !m_bank;
                    push_ev(EV_HIST, int'(m_bank));
                end else if (m_age == TIMEOUT + 1) begin
                    m_open = 0;
                    cause  = 1;
                end
            end else if (hop) begin
                m_open = 1;
                m_age  = 0;
                push_ev(EV_START, 0);
            end
        end
        if (cause && !m_fault) push_ev(EV_FAULT, 1);
        m_fault     = m_fault | cause;
        m_cfg_valid = !m_configured;
        m_busy      = m_open;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) model_reset();
        else model_step();
    end

    always @(posedge reset) model_reset();

    function automatic void check_event(int kind, int val, string name);
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].kind != kind) begin
            note_fail({name, " unexpected"}, val, -1);
        end else begin
            if (exp_q[0].val != val) note_fail({name, " value"}, val, exp_q[0].val);
            exp_q.delete(0);
        end
    endfunction

    logic [15:0] prev_dropped = '0;
    logic        prev_fault   = 1'b0;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            note_fail("missing event kind", -1, exp_q[0].kind);
            exp_q.delete(0);
        end
        if (!reset) begin
            if (bus.start) check_event(EV_START, 0, "start");
            if (bus.dropped != prev_dropped) check_event(EV_DROP, int'(bus.dropped), "dropped");
            if (bus.hist_ready) check_event(EV_HIST, int'(bus.bank), "hist_ready");
            if (bus.fault && !prev_fault) check_event(EV_FAULT, 1, "fault rise");
        end
        check("busy level", int'(bus.busy), int'(m_busy));
        check("bank level", int'(bus.bank), int'(m_bank));
        check("cfg_tvalid level", int'(bus.cfg_tvalid), int'(m_cfg_valid));
        check("fault level", int'(bus.fault), int'(m_fault));
        check("dropped level", int'(bus.dropped), m_drops);
        check("cfg_tdata", int'(bus.cfg_tdata), 1);
        prev_dropped = bus.dropped;
        prev_fault   = bus.fault;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobes(int n);
        for (int i = 0; i < n; i++) begin
            bus.sample_strobe = 1'b1;
            tick();
        end
        bus.sample_strobe = 1'b0;
    endtask

    // Frames are shortened to a few beats so they fit inside TIMEOUT; only
    // the final bin index matters to the scheduler.
    task automatic send_frame(int want_bank);
        logic [11:0] idx;
        idx = 12'd0;
        repeat ($urandom_range(40, 5)) begin
            bus.mag_valid = 1'b1;
            bus.mag_index = idx;
            tick();
            idx = 12'(int'(idx) + int'($urandom_range(100, 1)));
            if (idx > 12'd4094) idx = 12'd4094;
        end
        bus.mag_valid = 1'b1;
        bus.mag_index = 12'hFFF;
        tick();
        bus.mag_valid = 1'b0;
        bus.mag_index = 12'd0;
        check("bank after last bin", int'(bus.bank), want_bank);
        check("hist_ready after last bin", int'(bus.hist_ready), 1);
        check("busy after last bin", int'(bus.busy), 0);
        tick();
        check("hist_ready one cycle", int'(bus.hist_ready), 0);
    endtask

    task automatic random_phase(int n);
        for (int i = 0; i < n; i++) begin
            bus.sample_strobe = ($urandom_range(2) == 0);
            bus.mag_valid     = ($urandom_range(3) == 0);
            bus.mag_index     = ($urandom_range(15) == 0) ? 12'hFFF : 12'($urandom_range(4094));
            bus.cfg_tready    = ($urandom_range(1) == 1);
            tick();
        end
        bus.sample_strobe = 1'b0;
        bus.mag_valid     = 1'b0;
        bus.cfg_tready    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int high;
        int starts;
        int guard;

        bus.sample_strobe = 1'b0;
        bus.cfg_tready    = 1'b0;
        bus.mag_valid     = 1'b0;
        bus.mag_index     = 12'd0;
        bus.core_error    = 1'b0;

        repeat (3) tick();
        check("reset cfg_tvalid", int'(bus.cfg_tvalid), 0);
        check("reset start", int'(bus.start), 0);
        check("reset busy", int'(bus.busy), 0);
        reset = 1'b0;

        // Config handshake, with ignored strobes while the core is not ready.
        tick();
        check("cfg_tvalid first cycle", int'(bus.cfg_tvalid), 1);
        high = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.cfg_tvalid) high++;
            bus.sample_strobe = 1'b1;
            tick();
        end
        bus.sample_strobe = 1'b0;
        bus.cfg_tready    = 1'b1;
        if (bus.cfg_tvalid) high++;
        tick();
        bus.cfg_tready = 1'b0;
        check("cfg_tvalid high cycles", high, 6);
        check("cfg_tvalid after accept", int'(bus.cfg_tvalid), 0);

        // Fill plus first hop; start only after the 24th strobe.
        for (int s = 1; s <= FRAME + HOP; s++) begin
            bus.sample_strobe = 1'b1;
            tick();
            bus.sample_strobe = 1'b0;
            check("start after strobe", int'(bus.start), (s == FRAME + HOP) ? 1 : 0);
            if (s < FRAME + HOP) begin
                repeat ($urandom_range(2)) begin
                    tick();
                    check("start between strobes", int'(bus.start), 0);
                end
            end
        end
        check("busy in START", int'(bus.busy), 1);

        tick();
        send_frame(1);

        // Overrun: three hops while the frame is still open.
        strobes(HOP);
        check("start for overrun frame", int'(bus.start), 1);
        starts = 0;
        for (int i = 0; i < 3 * HOP; i++) begin
            bus.sample_strobe = 1'b1;
            tick();
            if (bus.start) starts++;
        end
        bus.sample_strobe = 1'b0;
        check("dropped after 3 hops", int'(bus.dropped), 3);
        check("no extra start", starts, 0);
        send_frame(0);
        strobes(HOP);
        check("start after overrun", int'(bus.start), 1);

        // Timeout: no magnitude beats at all.
        for (int k = 1; k <= TIMEOUT; k++) tick();
        check("fault before timeout", int'(bus.fault), 0);
        check("busy on last RUN cycle", int'(bus.busy), 1);
        tick();
        check("fault after timeout", int'(bus.fault), 1);
        check("busy after timeout", int'(bus.busy), 0);
        check("bank kept on timeout", int'(bus.bank), 0);
        strobes(HOP);
        check("start after timeout", int'(bus.start), 1);

        random_phase(3000);

        // Asynchronous reset in the middle of a frame.
        guard = 0;
        bus.sample_strobe = 1'b1;
        while (!bus.busy && guard < 100) begin
            tick();
            guard++;
        end
        bus.sample_strobe = 1'b0;
        check("busy before reset", int'(bus.busy), 1);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("async reset busy", int'(bus.busy), 0);
        check("async reset bank", int'(bus.bank), 0);
        check("async reset dropped", int'(bus.dropped), 0);
        check("async reset fault", int'(bus.fault), 0);
        check("async reset start", int'(bus.start), 0);
        check("async reset hist_ready", int'(bus.hist_ready), 0);
        check("async reset cfg_tvalid", int'(bus.cfg_tvalid), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("cfg_tvalid after reset", int'(bus.cfg_tvalid), 1);
        bus.cfg_tready = 1'b1;
        tick();
        bus.cfg_tready = 1'b0;
        check("fault before core_error", int'(bus.fault), 0);
        bus.core_error = 1'b1;
        tick();
        bus.core_error = 1'b0;
        check("fault from core_error", int'(bus.fault), 1);

        random_phase(500);
        repeat (5) tick();
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            note_fail("unconsumed event kind", -1, exp_q[0].kind);
            exp_q.delete(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_scheduler.md
# fft_scheduler

Sequencing controller for the `process_fft` datapath. It issues the one-time FFT core configuration and waits for the frame BRAM to fill. After that it emits a one-cycle `start` pulse (driving `process_fft`'s `ready`) every `HOP` incoming samples, and watches the magnitude stream to detect frame completion. It also owns the double-buffered histogram bank select, so the display path always reads a complete, stable spectrum.

## Interface
Parameters:
- `HOP`, 1024, samples between successive FFT starts (1..4096).
- `FRAME`, 4096, samples needed in the frame BRAM before the first start.
- `CFG_WORD`, 8'h01, word sent once on the core config channel (forward transform).
- `TIMEOUT`, 16384, max cycles in RUN before abort.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `sample_strobe` in 1: one-cycle pulse per sample written into the frame BRAM.
- `cfg_tdata` out 8: config payload, always `CFG_WORD`.
- `cfg_tvalid` out 1: config valid.
- `cfg_tready` in 1: config ready from the core.
- `start` out 1: one-cycle pulse that launches one frame in `process_fft`.
- `mag_valid` in 1: magnitude beat valid (core `magnitude_tvalid`).
- `mag_index` in 12: magnitude bin index (core `magnitude_tuser`).
- `core_error` in 1: sticky error from `process_fft`.
- `bank` out 1: histogram bank currently being written; the display reads `~bank`.
- `hist_ready` out 1: one-cycle pulse when `bank` toggles.
- `busy` out 1: high in START and RUN.
- `dropped` out 16: saturating count of skipped hops.
- `fault` out 1: sticky; set by timeout or `core_error`.

## Operation
States:
- **CFG:** `cfg_tvalid`=1. Exits to FILL on `cfg_tvalid && cfg_tready`.
- **FILL:** counts `sample_strobe` pulses up to `FRAME`. Exits to IDLE on the strobe that makes the count equal `FRAME`. The hop counter is cleared on that transition.
- **IDLE:** waits for `hop_due`.
- **START:** `start`=1 for exactly this cycle, then RUN unconditionally.
- **RUN:**
  - On `mag_valid && mag_index==12'hFFF`: toggle `bank`, pulse `hist_ready`, go to IDLE.
  - When the RUN cycle counter reaches `TIMEOUT`: set `fault`, go to IDLE. `bank` is not toggled.

Hop counter (12 bits):
- Counts `sample_strobe` in IDLE/START/RUN.
- When it reaches `HOP-1` and a strobe arrives, it wraps to 0 and raises `hop_due` for one cycle.
- `hop_due` in IDLE → START.
- `hop_due` in START or RUN → `dropped` += 1, saturating at 16'hFFFF. No queueing: the next start waits for the next hop.

Other rules:
- Completion and `hop_due` in the same RUN cycle: go to IDLE, increment `dropped`. That hop is lost.
- `core_error` high in any state sets `fault`. Sequencing continues; `fault` is diagnostic only.
- `sample_strobe` in CFG is ignored.
- Reset values: state CFG, all counters 0, `cfg_tvalid`=0 during reset, `start`=0, `bank`=0, `hist_ready`=0, `busy`=0, `dropped`=0, `fault`=0.
- Reset mid-RUN: returns to CFG and reconfigures the core. The half-written bank is abandoned; `bank` returns to 0.

## Timing
- All outputs are registered.
- `start` rises 1 cycle after the `sample_strobe` that completes a hop, given IDLE.
- `bank`/`hist_ready` update 1 cycle after the final magnitude beat (index 4095).
- `cfg_tvalid` first rises in the first cycle after reset deasserts. It holds until accepted and is never reasserted.
- First start: earliest 1 cycle after the `FRAME`-th strobe plus `HOP` further strobes.
- `dropped` updates 1 cycle after the offending `hop_due`.
- `fault` is set 1 cycle after the cause and clears only on reset.
- The timeout counter runs only in RUN and clears on entry to RUN.

## Structure
- Shared package `fft_pkg`:
  - state encoding typedef `sched_state_t` (CFG, FILL, IDLE, START, RUN);
  - constants `FFT_N`=4096, `FFT_LAST_IDX`=12'hFFF, `HIST_BINS`=1024, `CFG_FWD`=8'h01.
- One sub-module, `sat_counter` (parameterised width, saturating increment), used for `dropped`.
- Everything else is a single FSM with its counters.

## Test plan
Bench uses `HOP`=8, `FRAME`=16, `TIMEOUT`=64.
- **Config handshake:** hold `cfg_tready`=0 for 5 cycles, then 1 → `cfg_tvalid` high for exactly 6 cycles, then state FILL; strobes given before acceptance are not counted.
- **Fill then first start:** 16 strobes, then 8 more → exactly one `start` pulse, 1 cycle after the 24th strobe; no `start` before it.
- **Normal completion:** after `start`, drive `mag_valid` with indices 0..4095 → `bank` 0→1 and `hist_ready`=1 for one cycle, 1 cycle after index 4095; `busy` drops in the same cycle.
- **Overrun:** keep RUN open across 3 hops → `dropped`=3, no extra `start`; after completion, the next hop produces a `start`.
- **Timeout:** no magnitude beats after `start` → `fault`=1 at RUN cycle 64, state IDLE, `bank` unchanged; next hop restarts the frame.
- **Async reset mid-RUN:** assert `reset` between clock edges → all outputs at reset values immediately, `bank`=0, `dropped`=0; after release, `cfg_tvalid` rises again.
